// File: rtl/ysyx_csr_pkg.sv
// Shared encodings for the EXU CSR sequencer: op codes, machine CSR addresses,
// mstatus bit positions, trap causes and FSM states.
package ysyx_csr_pkg;

    localparam logic [2:0] OP_CSRRW = 3'd0;
    localparam logic [2:0] OP_CSRRS = 3'd1;
    localparam logic [2:0] OP_CSRRC = 3'd2;
    localparam logic [2:0] OP_ECALL = 3'd3;
    localparam logic [2:0] OP_MRET  = 3'd4;

    localparam logic [11:0] CSR_NONE      = 12'h000;
    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;

    localparam int unsigned MSTATUS_MIE  = 3;
    localparam int unsigned MSTATUS_MPIE = 7;

    localparam logic [31:0] CAUSE_ECALL_M      = 32'd11;
    localparam logic [31:0] CAUSE_ILLEGAL_INSN = 32'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } csr_state_e;

    function automatic logic csr_known(input logic [11:0] addr);
        return (addr == CSR_MSTATUS) || (addr == CSR_MTVEC) || (addr == CSR_MEPC) ||
               (addr == CSR_MCAUSE) || (addr == CSR_MVENDORID) || (addr == CSR_MARCHID);
    endfunction

endpackage

// File: rtl/ysyx_csr_alu.sv
// Read-modify-write datapath: new CSR value and write enable from op and old value.
module ysyx_csr_alu
    import ysyx_csr_pkg::*;
#(
    parameter int BIT_W = 32
) (
    input  logic [2:0]       op_i,
    input  logic [BIT_W-1:0] old_i,
    input  logic [BIT_W-1:0] src_i,
    input  logic             src_zero_i,
    output logic             wen_o,
    output logic [BIT_W-1:0] wdata_o
);

    always_comb begin
        wen_o   = 1'b0;
        wdata_o = '0;
        case (op_i)
            OP_CSRRW: begin
                wen_o   = 1'b1;
                wdata_o = src_i;
            end
            // Set/clear with rs1=x0 / zimm=0 is a pure read.
            OP_CSRRS: begin
                wen_o   = !src_zero_i;
                wdata_o = old_i | src_i;
            end
            OP_CSRRC: begin
                wen_o   = !src_zero_i;
                wdata_o = old_i & ~src_i;
            end
            // ECALL data is the PC, supplied by the sequencer.
            OP_ECALL: wen_o = 1'b1;
            OP_MRET: begin
                wen_o                 = 1'b1;
                wdata_o               = old_i;
                wdata_o[MSTATUS_MIE]  = old_i[MSTATUS_MPIE];
                wdata_o[MSTATUS_MPIE] = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ysyx_exu_csr_ctrl.sv
// EXU CSR access sequencer: IDLE -> READ -> WRITE -> RESP per op.
// Optional macro YSYX_CSR_ILLEGAL_TRAP_EN turns illegal CSR accesses into traps.
module ysyx_exu_csr_ctrl
    import ysyx_csr_pkg::*;
#(
    parameter int BIT_W = 32,
    parameter int R_W   = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [R_W-1:0]   req_addr,
    input  logic [BIT_W-1:0] req_src,
    input  logic             req_src_zero,
    input  logic [BIT_W-1:0] req_pc,
    output logic [R_W-1:0]   csr_addr,
    input  logic [BIT_W-1:0] csr_rdata,
    input  logic [BIT_W-1:0] csr_mtvec,
    input  logic [BIT_W-1:0] csr_mepc,
    output logic             csr_wen,
    output logic             csr_ecallen,
    output logic [BIT_W-1:0] csr_wdata,
    output logic [R_W-1:0]   csr_addr_add1,
    output logic [BIT_W-1:0] csr_wdata_add1,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [BIT_W-1:0] rsp_rd_data,
    output logic             rsp_redirect,
    output logic [BIT_W-1:0] rsp_npc,
    output logic [1:0]       dbg_state_o
);

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // valid never depends on ready, and rsp_* hold steady while rsp_ready is low.

    csr_state_e       state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [R_W-1:0]   addr_q, addr_d;
    logic [BIT_W-1:0] src_q, src_d, pc_q, pc_d;
    logic             src_zero_q, src_zero_d;
    logic [BIT_W-1:0] old_q, old_d, mtvec_q, mtvec_d, mepc_q, mepc_d;

    logic             alu_wen;
    logic [BIT_W-1:0] alu_wdata;
    logic             is_csr_op;
    logic             trap;

    ysyx_csr_alu #(.BIT_W(BIT_W)) u_alu (
        .op_i       (op_q),
        .old_i      (old_q),
        .src_i      (src_q),
        .src_zero_i (src_zero_q),
        .wen_o      (alu_wen),
        .wdata_o    (alu_wdata)
    );

    assign is_csr_op   = (op_q == OP_CSRRW) || (op_q == OP_CSRRS) || (op_q == OP_CSRRC);
    assign dbg_state_o = state_q;

`ifdef YSYX_CSR_ILLEGAL_TRAP_EN
    assign trap = is_csr_op &&
                  (!csr_known(12'(addr_q)) ||
                   (alu_wen && ((addr_q == R_W'(CSR_MVENDORID)) || (addr_q == R_W'(CSR_MARCHID)))));
`else
    assign trap = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            op_q       <= '0;
            addr_q     <= '0;
            src_q      <= '0;
            src_zero_q <= 1'b0;
            pc_q       <= '0;
            old_q      <= '0;
            mtvec_q    <= '0;
            mepc_q     <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            src_q      <= src_d;
            src_zero_q <= src_zero_d;
            pc_q       <= pc_d;
            old_q      <= old_d;
            mtvec_q    <= mtvec_d;
            mepc_q     <= mepc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        src_d      = src_q;
        src_zero_d = src_zero_q;
        pc_d       = pc_q;
        old_d      = old_q;
        mtvec_d    = mtvec_q;
        mepc_d     = mepc_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d       = req_op;
                    addr_d     = req_addr;
                    src_d      = req_src;
                    src_zero_d = req_src_zero;
                    pc_d       = req_pc;
                    state_d    = ST_READ;
                end
            end
            ST_READ: begin
                old_d   = csr_rdata;
                mtvec_d = csr_mtvec;
                mepc_d  = csr_mepc;
                state_d = ST_WRITE;
            end
            ST_WRITE: state_d = ST_RESP;
            ST_RESP:  if (rsp_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready      = (state_q == ST_IDLE);
        csr_addr       = '0;
        csr_wen        = 1'b0;
        csr_ecallen    = 1'b0;
        csr_wdata      = '0;
        csr_addr_add1  = R_W'(CSR_NONE);
        csr_wdata_add1 = '0;
        rsp_valid      = 1'b0;
        rsp_rd_data    = '0;
        rsp_redirect   = 1'b0;
        rsp_npc        = '0;
        case (state_q)
            ST_READ: csr_addr = (op_q == OP_MRET) ? R_W'(CSR_MSTATUS) : addr_q;
            ST_WRITE: begin
                // ECALL and illegal-access traps share the mepc/mcause dual write.
                if (trap || (op_q == OP_ECALL)) begin
                    csr_wen        = 1'b1;
                    csr_ecallen    = 1'b1;
                    csr_addr       = R_W'(CSR_MEPC);
                    csr_wdata      = pc_q;
                    csr_addr_add1  = R_W'(CSR_MCAUSE);
                    csr_wdata_add1 = trap ? BIT_W'(CAUSE_ILLEGAL_INSN) : BIT_W'(CAUSE_ECALL_M);
                end else begin
                    csr_wen   = alu_wen;
                    csr_addr  = (op_q == OP_MRET) ? R_W'(CSR_MSTATUS) : addr_q;
                    csr_wdata = alu_wdata;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (trap || (op_q == OP_ECALL)) begin
                    rsp_redirect = 1'b1;
                    rsp_npc      = mtvec_q;
                end else if (op_q == OP_MRET) begin
                    rsp_redirect = 1'b1;
                    rsp_npc      = mepc_q;
                end else if (is_csr_op) begin
                    rsp_rd_data = old_q;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ysyx_exu_csr_ctrl.sv
// Self-checking bench for ysyx_exu_csr_ctrl: small CSR file environment plus an
// op-level reference model predicting write-slot and response values.
module tb_ysyx_exu_csr_ctrl;
    import ysyx_csr_pkg::*;

    localparam int BIT_W = 32;
    localparam int R_W   = 12;
    localparam logic [31:0] VENDOR_ID = 32'h0000_079F;
    localparam logic [31:0] ARCH_ID   = 32'h0000_0005;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [2:0]       req_op = '0;
    logic [R_W-1:0]   req_addr = '0;
    logic [BIT_W-1:0] req_src = '0;
    logic             req_src_zero = 1'b0;
    logic [BIT_W-1:0] req_pc = '0;
    logic [R_W-1:0]   csr_addr;
    logic [BIT_W-1:0] csr_rdata;
    logic [BIT_W-1:0] csr_mtvec;
    logic [BIT_W-1:0] csr_mepc;
    logic             csr_wen;
    logic             csr_ecallen;
    logic [BIT_W-1:0] csr_wdata;
    logic [R_W-1:0]   csr_addr_add1;
    logic [BIT_W-1:0] csr_wdata_add1;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [BIT_W-1:0] rsp_rd_data;
    logic             rsp_redirect;
    logic [BIT_W-1:0] rsp_npc;
    logic [1:0]       dbg_state;

    ysyx_exu_csr_ctrl #(.BIT_W(BIT_W), .R_W(R_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .req_addr       (req_addr),
        .req_src        (req_src),
        .req_src_zero   (req_src_zero),
        .req_pc         (req_pc),
        .csr_addr       (csr_addr),
        .csr_rdata      (csr_rdata),
        .csr_mtvec      (csr_mtvec),
        .csr_mepc       (csr_mepc),
        .csr_wen        (csr_wen),
        .csr_ecallen    (csr_ecallen),
        .csr_wdata      (csr_wdata),
        .csr_addr_add1  (csr_addr_add1),
        .csr_wdata_add1 (csr_wdata_add1),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_rd_data    (rsp_rd_data),
        .rsp_redirect   (rsp_redirect),
        .rsp_npc        (rsp_npc),
        .dbg_state_o    (dbg_state)
    );

    always #5 clk = ~clk;

    // Environment CSR file: combinational read, write on the clock edge.
    logic [31:0] rf_mstatus = '0, rf_mtvec = '0, rf_mepc = '0, rf_mcause = '0;

    always_comb begin
        case (csr_addr)
            12'h300: csr_rdata = rf_mstatus;
            12'h305: csr_rdata = rf_mtvec;
            12'h341: csr_rdata = rf_mepc;
            12'h342: csr_rdata = rf_mcause;
            12'hF11: csr_rdata = VENDOR_ID;
            12'hF12: csr_rdata = ARCH_ID;
            default: csr_rdata = '0;
        endcase
    end
    assign csr_mtvec = rf_mtvec;
    assign csr_mepc  = rf_mepc;

    task automatic rf_write(input logic [11:0] a, input logic [31:0] d);
        case (a)
            12'h300: rf_mstatus <= d;
            12'h305: rf_mtvec   <= d;
            12'h341: rf_mepc    <= d;
            12'h342: rf_mcause  <= d;
            default: ;
        endcase
    endtask

    always @(posedge clk) begin
        if (csr_wen) begin
            rf_write(csr_addr, csr_wdata);
            if (csr_addr_add1 != 12'h000) rf_write(csr_addr_add1, csr_wdata_add1);
        end
    end

    function automatic logic [31:0] rf_peek(input logic [11:0] a);
        case (a)
            12'h300: return rf_mstatus;
            12'h305: return rf_mtvec;
            12'h341: return rf_mepc;
            12'h342: return rf_mcause;
            12'hF11: return VENDOR_ID;
            12'hF12: return ARCH_ID;
            default: return 32'h0;
        endcase
    endfunction

    typedef struct packed {
        logic        wen;
        logic        ecallen;
        logic        redir;
        logic [11:0] raddr;
        logic [11:0] waddr;
        logic [11:0] add1;
        logic [31:0] wdata;
        logic [31:0] wd1;
        logic [31:0] rd;
        logic [31:0] npc;
    } exp_t;

    // Reference model: what one op should do given the current CSR contents.
    function automatic exp_t predict(input logic [2:0] op, input logic [11:0] addr,
                                     input logic [31:0] src, input logic zero,
                                     input logic [31:0] pc);
        exp_t e;
        logic [31:0] old;
        e       = '0;
        e.raddr = (op == 3'd4) ? 12'h300 : addr;
        e.waddr = e.raddr;
        old     = rf_peek(e.raddr);
        case (op)
            3'd0: begin e.wen = 1'b1;  e.wdata = src;        e.rd = old; end
            3'd1: begin e.wen = !zero; e.wdata = old | src;  e.rd = old; end
            3'd2: begin e.wen = !zero; e.wdata = old & ~src; e.rd = old; end
            3'd3: begin
                e.wen = 1'b1; e.ecallen = 1'b1; e.waddr = 12'h341; e.wdata = pc;
                e.add1 = 12'h342; e.wd1 = 32'd11; e.redir = 1'b1; e.npc = rf_mtvec;
            end
            3'd4: begin
                e.wen   = 1'b1;
                e.wdata = {old[31:8], 1'b1, old[6:4], old[7], old[2:0]};
                e.redir = 1'b1; e.npc = rf_mepc;
            end
            default: ;
        endcase
`ifdef YSYX_CSR_ILLEGAL_TRAP_EN
        if ((op <= 3'd2) && (!(addr inside {12'h300, 12'h305, 12'h341, 12'h342, 12'hF11, 12'hF12}) ||
                             (e.wen && (addr inside {12'hF11, 12'hF12})))) begin
            e.wen = 1'b1; e.ecallen = 1'b1; e.waddr = 12'h341; e.wdata = pc;
            e.add1 = 12'h342; e.wd1 = 32'd2; e.rd = '0; e.redir = 1'b1; e.npc = rf_mtvec;
        end
`endif
        return e;
    endfunction

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Runs one op from IDLE (called at a negedge), holding rsp_ready low for 'hold' cycles.
    task automatic run_op(input logic [2:0] op, input logic [11:0] addr, input logic [31:0] src,
                          input logic zero, input logic [31:0] pc, input int hold);
        exp_t e;
        e = predict(op, addr, src, zero, pc);
        req_valid = 1'b1; req_op = op; req_addr = addr;
        req_src = src; req_src_zero = zero; req_pc = pc;
        check_eq("idle_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        // Scramble request inputs: the op must have been latched at accept.
        req_valid = 1'b0; req_op = 3'($urandom); req_addr = 12'($urandom);
        req_src = $urandom; req_src_zero = 1'($urandom); req_pc = $urandom;
        check_eq("read_state", 32'(dbg_state), 32'(ST_READ));
        check_eq("read_addr", 32'(csr_addr), 32'(e.raddr));
        check_eq("read_wen", 32'(csr_wen), 32'd0);
        check_eq("read_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check_eq("write_wen", 32'(csr_wen), 32'(e.wen));
        check_eq("write_ecallen", 32'(csr_ecallen), 32'(e.ecallen));
        check_eq("write_add1", 32'(csr_addr_add1), 32'(e.add1));
        check_eq("write_rsp_valid", 32'(rsp_valid), 32'd0);
        if (e.wen) begin
            check_eq("write_addr", 32'(csr_addr), 32'(e.waddr));
            check_eq("write_wdata", csr_wdata, e.wdata);
        end
        if (e.ecallen) check_eq("write_wdata_add1", csr_wdata_add1, e.wd1);
        @(negedge clk);
        for (int i = 0; i <= hold; i++) begin
            if (i == hold) rsp_ready = 1'b1;
            check_eq("rsp_valid", 32'(rsp_valid), 32'd1);
            check_eq("rsp_rd_data", rsp_rd_data, e.rd);
            check_eq("rsp_redirect", 32'(rsp_redirect), 32'(e.redir));
            check_eq("rsp_npc", rsp_npc, e.npc);
            check_eq("rsp_req_ready", 32'(req_ready), 32'd0);
            check_eq("rsp_wen", 32'(csr_wen | csr_ecallen), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b0;
        check_eq("done_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("done_req_ready", 32'(req_ready), 32'd1);
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
        check_eq({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        check_eq({tag, "_wen"}, 32'(csr_wen), 32'd0);
        check_eq({tag, "_ecallen"}, 32'(csr_ecallen), 32'd0);
        check_eq({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check_eq({tag, "_redirect"}, 32'(rsp_redirect), 32'd0);
        check_eq({tag, "_addr"}, 32'(csr_addr), 32'd0);
        check_eq({tag, "_wdata"}, csr_wdata, 32'd0);
        check_eq({tag, "_add1"}, 32'(csr_addr_add1), 32'd0);
        check_eq({tag, "_rd_data"}, rsp_rd_data, 32'd0);
        check_eq({tag, "_npc"}, rsp_npc, 32'd0);
    endtask

    logic [11:0] addr_tab [8];
    logic [31:0] mtvec_before;

    initial begin
        addr_tab = '{12'h300, 12'h305, 12'h341, 12'h342, 12'hF11, 12'hF12, 12'h7C0, 12'h123};

        // Reset with a request pending: nothing may be accepted.
        req_valid = 1'b1; req_op = OP_CSRRW; req_addr = 12'h305; req_src = 32'hDEAD_BEEF;
        repeat (3) @(negedge clk);
        check_quiet("reset");
        req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check_quiet("post_reset");

        // Directed scenarios.
        rf_mtvec = 32'h0;
        run_op(OP_CSRRW, 12'h305, 32'h8000_0100, 1'b0, 32'h8000_0000, 0);
        check_eq("mtvec_written", rf_mtvec, 32'h8000_0100);
        rf_mstatus = 32'h1808;
        run_op(OP_CSRRS, 12'h300, 32'h0, 1'b1, 32'h8000_0004, 0);
        check_eq("mstatus_unchanged", rf_mstatus, 32'h1808);
        rf_mstatus = 32'h88;
        run_op(OP_CSRRC, 12'h300, 32'h8, 1'b0, 32'h8000_0008, 0);
        run_op(OP_ECALL, 12'h000, 32'h0, 1'b1, 32'h8000_0010, 1);
        check_eq("ecall_mepc", rf_mepc, 32'h8000_0010);
        check_eq("ecall_mcause", rf_mcause, 32'd11);
        rf_mstatus = 32'h80; rf_mepc = 32'h8000_0014;
        run_op(OP_MRET, 12'h000, 32'h0, 1'b1, 32'h8000_0018, 0);
        run_op(OP_CSRRW, 12'hF11, 32'h1234_5678, 1'b0, 32'h8000_001C, 0);
        run_op(3'd6, 12'h300, 32'hFFFF_FFFF, 1'b0, 32'h8000_0020, 0);
        run_op(OP_CSRRS, 12'h341, 32'h0000_0F00, 1'b0, 32'h8000_0024, 5);

        // Reset asserted mid-WRITE must kill the pulse and the response.
        mtvec_before = rf_mtvec;
        req_valid = 1'b1; req_op = OP_CSRRW; req_addr = 12'h305;
        req_src = 32'h5555_AAAA; req_src_zero = 1'b0; req_pc = 32'h8000_0030;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check_eq("abort_wen_before", 32'(csr_wen), 32'd1);
        rst = 1'b0;
        #1;
        check_quiet("abort");
        @(negedge clk);
        rst = 1'b1;
        check_eq("abort_mtvec_kept", rf_mtvec, mtvec_before);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("abort_no_rsp", 32'(rsp_valid), 32'd0);
        end

        // Randomized ops against the model.
        for (int n = 0; n < 60; n++) begin
            logic [2:0]  op;
            logic [11:0] a;
            logic        z;
            op = 3'($urandom_range(0, 7));
            a  = addr_tab[$urandom_range(0, 7)];
            z  = ($urandom_range(0, 3) == 0);
            run_op(op, a, z ? 32'h0 : $urandom, z, $urandom & 32'hFFFF_FFFC, $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
